// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : alu_pkg
// Summary  : Opcodes, FSM state type and op classification for alu_mc.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_NOT  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_INC  = 4'b0111;
    localparam logic [3:0] OP_DEC  = 4'b1000;
    localparam logic [3:0] OP_CLR  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter
// Summary  : Shift-add multiplier / restoring divider, one bit per cycle.
// Revision : 1.0
// ============================================================================
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic             r_run;
    logic             r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // r_hi:r_lo is the partial product (mul) or remainder:dividend (div)
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_shift  = {r_hi, r_lo[WIDTH-1]};
        w_trial  = w_shift - {1'b0, r_m};
        w_hi_nxt = w_sum[WIDTH:1];
        w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        if (r_div) begin
            if (!w_trial[WIDTH]) begin
                w_hi_nxt = w_trial[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_div <= 1'b0;
            r_cnt <= '0;
            r_m   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (abort) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (start) begin
            r_run <= 1'b1;
            r_div <= is_div;
            r_cnt <= '0;
            r_m   <= is_div ? b : a;
            r_lo  <= is_div ? a : b;
            r_hi  <= '0;
        end else if (r_run) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == c_last) begin
                r_run <= 1'b0;
            end
        end
    end

    // High during the final step so the FSM leaves BUSY as the counter hits WIDTH
    assign done    = r_run && (r_cnt == c_last);
    assign prod_hi = r_hi;
    assign prod_lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Summary  : Multi-cycle EX-stage ALU with valid/ready handshake and MULU/DIVU.
// Revision : 1.0
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_ovf;
    logic             r_err;

    logic             w_accept;
    logic             w_go_mc;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_hi;
    logic [WIDTH-1:0] w_iter_lo;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_hi;
    logic             w_ovf;
    logic             w_err;

    assign w_accept = in_valid && (r_state == IDLE) && !flush;
    // Divide by zero is resolved on the single-cycle path
    assign w_go_mc  = is_multicycle(aluop) && !((aluop == OP_DIVU) && (b == '0));

    alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort   (flush),
        .start   (w_accept && w_go_mc),
        .is_div  (aluop == OP_DIVU),
        .a       (a),
        .b       (b),
        .done    (w_iter_done),
        .prod_hi (w_iter_hi),
        .prod_lo (w_iter_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_go_mc ? BUSY : DONE;
            BUSY:    if (w_iter_done) w_state_nxt = DONE;
            DONE:    if (r_out_valid && out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
        end
    end

    assign w_add = r_a + r_b;
    assign w_sub = r_a - r_b;

    always_comb begin
        w_res = '0;
        w_hi  = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (r_op)
            OP_PASS: w_res = r_a;
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_NOT:  w_res = ~r_a;
            OP_XOR:  w_res = r_a ^ r_b;
            OP_ADD: begin
                w_res = w_add;
                w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub;
                w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_INC: begin
                w_res = r_a + WIDTH'(1);
                w_ovf = (r_a == c_max_pos);
            end
            OP_DEC: begin
                w_res = r_a - WIDTH'(1);
                w_ovf = (r_a == c_min_neg);
            end
            OP_CLR:  w_res = '0;
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_MULU: begin
                w_res = w_iter_lo;
                w_hi  = w_iter_hi;
            end
            OP_DIVU: begin
                if (r_b == '0) begin
                    w_res = '1;
                    w_hi  = r_a;
                    w_err = 1'b1;
                end else begin
                    w_res = w_iter_lo;
                    w_hi  = w_iter_hi;
                end
            end
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= OP_PASS;
        end else if (w_accept) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= aluop;
        end
    end

    // Outputs load once on the first DONE cycle and then hold until transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_hi        <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (r_state == DONE) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_hi        <= w_hi;
                r_zero      <= (r_a == r_b);
                r_ovf       <= w_ovf;
                r_err       <= w_err;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign hi        = r_hi;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule
`default_nettype wire
